// File: rtl/loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory loader.
package loader_pkg;

    localparam int ADDR_W    = 6;
    localparam int MAX_WORDS = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_e;

endpackage

// File: rtl/word_packer.sv
// Packs accepted stream bytes big-endian into 32-bit words; word_valid_o pulses
// for one cycle after the fourth byte of a word, while word_o holds that word.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] shift_q;
    logic [31:0] shift_d;
    logic        word_valid_q;

    assign last_byte_o = byte_en_i && (cnt_q == 2'd3);
    assign cnt_d       = byte_en_i ? cnt_q + 2'd1 : cnt_q;
    assign shift_d     = byte_en_i ? {shift_q[23:0], byte_i} : shift_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q        <= 2'd0;
            shift_q      <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= last_byte_o;
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into an external
// instruction RAM and holds the core in reset until a good load completes.
module imem_loader #(
    parameter int ADDR_W    = loader_pkg::ADDR_W,
    parameter int MAX_WORDS = loader_pkg::MAX_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    import loader_pkg::*;

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  nwords_q, nwords_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              core_reset_q;
    logic              done_q;
    logic              error_q;

    logic accept;
    logic load_byte;
    logic last_byte;
    logic header_ok;

    assign in_ready  = ((state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CHECK))
                       && !restart && !reset;
    assign accept    = in_valid && in_ready;
    assign load_byte = accept && (state_q == ST_LOAD);
    assign header_ok = (in_data != 8'd0) && (32'(in_data) <= MAX_WORDS);

    word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (restart),
        .byte_en_i    (load_byte),
        .byte_i       (in_data),
        .last_byte_o  (last_byte),
        .word_valid_o (wr_en),
        .word_o       (wr_data)
    );

    always_comb begin
        state_d    = state_q;
        nwords_d   = nwords_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        wr_addr_d  = wr_addr_q;
        if (restart) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
            csum_d     = 8'd0;
            wr_addr_d  = '0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (header_ok) begin
                        nwords_d = CNT_W'(in_data);
                        state_d  = ST_LOAD;
                    end else begin
                        state_d  = ST_ERROR;
                    end
                end
                ST_LOAD: begin
                    csum_d = csum_q ^ in_data;
                    if (last_byte) begin
                        // Address latched alongside the packer's registered word.
                        wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (word_cnt_q == nwords_q - CNT_W'(1)) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            nwords_q     <= '0;
            word_cnt_q   <= '0;
            csum_q       <= 8'd0;
            wr_addr_q    <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            nwords_q     <= nwords_d;
            word_cnt_q   <= word_cnt_d;
            csum_q       <= csum_d;
            wr_addr_q    <= wr_addr_d;
            core_reset_q <= (state_d != ST_DONE);
            done_q       <= (state_d == ST_DONE);
            error_q      <= (state_d == ST_ERROR);
        end
    end

    assign wr_addr    = wr_addr_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
